// File: rtl/sync_pkg.sv
// Shared constants and helpers for the slow-to-fast level synchroniser.
// The optional sticky event flags are enabled by defining SLOW2FAST_STICKY_EVENT_EN.
package sync_pkg;

    localparam int SYNC_MIN_STAGES     = 2;
    localparam int SYNC_DEFAULT_FILTER = 4;

    // Counter width able to hold 0..value-1, never narrower than one bit.
    function automatic int clog2(input int value);
        int width;
        width = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            width++;
        end
        if (width < 1) begin
            width = 1;
        end
        return width;
    endfunction

endpackage

// File: rtl/sync_filter_ch.sv
// One channel: flop chain, stability filter and registered edge pulses.
// With SLOW2FAST_STICKY_EVENT_EN defined, a sticky event flag is also kept.
module sync_filter_ch
    import sync_pkg::*;
#(
    parameter int   STAGES        = SYNC_MIN_STAGES,
    parameter int   FILTER_CYCLES = SYNC_DEFAULT_FILTER,
    parameter logic RESET_VAL     = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic async_i,
    input  logic clr_i,
    output logic sync_o,
    output logic sync_up_o,
    output logic sync_down_o,
    output logic update_o,
    output logic event_o
);

    localparam int              CNT_W    = clog2(FILTER_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

    if (STAGES < SYNC_MIN_STAGES) begin : g_bad_stages
        $error("sync_filter_ch: STAGES must be at least %0d", SYNC_MIN_STAGES);
    end
    if (FILTER_CYCLES < 1) begin : g_bad_filter
        $error("sync_filter_ch: FILTER_CYCLES must be at least 1");
    end

    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] chain_q;
    logic [STAGES-1:0] chain_d;
    logic              synced;
    logic              update;
    logic              level_q, level_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              up_q, up_d;
    logic              down_q, down_d;

    // The counter only advances while the synchronised value disagrees with
    // the filtered level; any return to agreement discards the partial count.
    always_comb begin
        chain_d = {chain_q[STAGES-2:0], async_i};
        synced  = chain_q[STAGES-1];
        update  = 1'b0;
        level_d = level_q;
        cnt_d   = cnt_q;
        if (synced == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            update  = 1'b1;
            level_d = synced;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        up_d   = update & synced;
        down_d = update & ~synced;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            chain_q <= {STAGES{RESET_VAL}};
            level_q <= RESET_VAL;
            cnt_q   <= '0;
            up_q    <= 1'b0;
            down_q  <= 1'b0;
        end else begin
            chain_q <= chain_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            up_q    <= up_d;
            down_q  <= down_d;
        end
    end

    assign sync_o      = level_q;
    assign sync_up_o   = up_q;
    assign sync_down_o = down_q;
    assign update_o    = update & rst_ni;

`ifdef SLOW2FAST_STICKY_EVENT_EN
    logic event_q, event_d;

    // A new edge wins over a clear arriving on the same clock.
    always_comb begin
        event_d = update | (event_q & ~clr_i);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            event_q <= 1'b0;
        end else begin
            event_q <= event_d;
        end
    end

    assign event_o = event_q;
`else
    logic unused_clr;
    assign unused_clr = clr_i;
    assign event_o    = 1'b0;
`endif

endmodule

// File: rtl/slow_2_fast_sync_bus.sv
// WIDTH independent slow-to-fast level synchronisers with a shared any-edge flag.
// Sticky per-channel event flags exist only when SLOW2FAST_STICKY_EVENT_EN is defined.
module slow_2_fast_sync_bus
    import sync_pkg::*;
#(
    parameter int               WIDTH         = 4,
    parameter int               STAGES        = SYNC_MIN_STAGES,
    parameter int               FILTER_CYCLES = SYNC_DEFAULT_FILTER,
    parameter logic [WIDTH-1:0] RESET_VAL     = {WIDTH{1'b0}}
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] async_i,
    output logic [WIDTH-1:0] sync_o,
    output logic [WIDTH-1:0] sync_up_o,
    output logic [WIDTH-1:0] sync_down_o,
    output logic             any_edge_o,
    input  logic [WIDTH-1:0] clr_i,
    output logic [WIDTH-1:0] event_o
);

    if (WIDTH < 1) begin : g_bad_width
        $error("slow_2_fast_sync_bus: WIDTH must be at least 1");
    end

    logic [WIDTH-1:0] update;
    logic             any_edge_q, any_edge_d;

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        sync_filter_ch #(
            .STAGES        (STAGES),
            .FILTER_CYCLES (FILTER_CYCLES),
            .RESET_VAL     (RESET_VAL[i])
        ) u_ch (
            .clk_i       (clk_i),
            .rst_ni      (rst_ni),
            .async_i     (async_i[i]),
            .clr_i       (clr_i[i]),
            .sync_o      (sync_o[i]),
            .sync_up_o   (sync_up_o[i]),
            .sync_down_o (sync_down_o[i]),
            .update_o    (update[i]),
            .event_o     (event_o[i])
        );
    end

    // Registered from the same update strobes as the pulses so it lines up with them.
    always_comb begin
        any_edge_d = |update;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            any_edge_q <= 1'b0;
        end else begin
            any_edge_q <= any_edge_d;
        end
    end

    assign any_edge_o = any_edge_q;

endmodule
